// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: key map, per-scan
// result encoding, FSM states and the column reset pattern.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned LINES = 4;

    // Column pattern after reset: column 0 driven low.
    localparam logic [LINES-1:0] COL_RESET = 4'b1110;

    // Key code at [row][column] (Digilent KYPD layout).
    localparam logic [KEY_W-1:0] KEY_MAP [LINES][LINES] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_t;

    // Code is forced to zero unless kind is SINGLE so whole-struct compares work.
    typedef struct packed {
        res_kind_t        kind;
        logic [KEY_W-1:0] code;
    } scan_result_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: mclk clock, reset async active-low, d async input, q synchronized output.
module sync_2ff #(
    parameter int unsigned         WIDTH     = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL = '1
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates one active-low column, samples the rows at the
// end of each dwell, classifies every full scan, debounces across scans and
// reports accepted presses/releases as one-cycle ticks.
// Ports: mclk clock; reset async active-low; row[3:0] active-low keypad rows;
//        col[3:0] active-low column drive; key_code last accepted key;
//        key_valid accepted key held; key_tick press pulse; release_tick release pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 16,
    parameter int unsigned DB_SCANS  = 4
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [LINES-1:0] row,
    output logic [LINES-1:0] col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_tick,
    output logic             release_tick
);

    localparam int unsigned   STABLE_W = 4;
    localparam logic [STABLE_W-1:0] DB_MAX = STABLE_W'(DB_SCANS);

    logic [LINES-1:0]     row_sync;
    logic [SCAN_BITS-1:0] dwell_q;
    logic [1:0]           col_idx_q;
    logic [1:0]           acc_cnt_q;     // 0, 1 or 2 (=more than one) low bits so far
    logic [KEY_W-1:0]     acc_code_q;
    scan_result_t         prev_q;
    logic [STABLE_W-1:0]  stable_q;
    state_t               state_q;

    logic                 sample_c;
    logic                 scan_done_c;
    logic [2:0]           low_cnt_c;
    logic [1:0]           low_row_c;
    logic [2:0]           sum_c;
    logic [1:0]           merged_cnt_c;
    logic [KEY_W-1:0]     merged_code_c;
    scan_result_t         result_c;
    logic [STABLE_W-1:0]  stable_d;

    state_t               state_d;
    logic [KEY_W-1:0]     code_d;
    logic                 valid_d;
    logic                 key_tick_d;
    logic                 release_tick_d;

    sync_2ff #(
        .WIDTH     (LINES),
        .RESET_VAL ({LINES{1'b1}})
    ) u_row_sync (
        .mclk  (mclk),
        .reset (reset),
        .d     (row),
        .q     (row_sync)
    );

    // Merge this column's sample into the running scan classification.
    always_comb begin
        sample_c    = &dwell_q;
        scan_done_c = sample_c && (col_idx_q == 2'd3);
        low_cnt_c   = 3'd0;
        low_row_c   = 2'd0;
        for (int r = 0; r < int'(LINES); r++) begin
            if (!row_sync[r]) begin
                low_cnt_c = low_cnt_c + 3'd1;
                low_row_c = 2'(r);
            end
        end
        sum_c         = 3'({1'b0, acc_cnt_q}) + low_cnt_c;
        merged_cnt_c  = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
        merged_code_c = (acc_cnt_q == 2'd0 && low_cnt_c == 3'd1)
                        ? KEY_MAP[low_row_c][col_idx_q] : acc_code_q;

        result_c.kind = RES_MULTI;
        result_c.code = '0;
        if (merged_cnt_c == 2'd0) begin
            result_c.kind = RES_NONE;
        end else if (merged_cnt_c == 2'd1) begin
            result_c.kind = RES_SINGLE;
            result_c.code = merged_code_c;
        end

        stable_d = stable_q;
        if (scan_done_c) begin
            if (result_c == prev_q) begin
                stable_d = (stable_q >= DB_MAX) ? DB_MAX : stable_q + STABLE_W'(1);
            end else begin
                stable_d = STABLE_W'(1);
            end
        end
    end

    // Press/release acceptance, evaluated only when a scan completes.
    always_comb begin
        state_d        = state_q;
        code_d         = key_code;
        valid_d        = key_valid;
        key_tick_d     = 1'b0;
        release_tick_d = 1'b0;
        if (scan_done_c && stable_d == DB_MAX) begin
            case (state_q)
                ST_IDLE: begin
                    if (result_c.kind == RES_SINGLE) begin
                        code_d     = result_c.code;
                        valid_d    = 1'b1;
                        key_tick_d = 1'b1;
                        state_d    = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (result_c.kind == RES_NONE) begin
                        valid_d        = 1'b0;
                        release_tick_d = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            dwell_q      <= '0;
            col_idx_q    <= 2'd0;
            col          <= COL_RESET;
            acc_cnt_q    <= 2'd0;
            acc_code_q   <= '0;
            prev_q       <= '{kind: RES_NONE, code: '0};
            stable_q     <= '0;
            state_q      <= ST_IDLE;
            key_code     <= '0;
            key_valid    <= 1'b0;
            key_tick     <= 1'b0;
            release_tick <= 1'b0;
        end else begin
            dwell_q      <= dwell_q + SCAN_BITS'(1);
            state_q      <= state_d;
            key_code     <= code_d;
            key_valid    <= valid_d;
            key_tick     <= key_tick_d;
            release_tick <= release_tick_d;
            if (sample_c) begin
                col       <= {col[LINES-2:0], col[LINES-1]};
                col_idx_q <= col_idx_q + 2'd1;
                if (scan_done_c) begin
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= '0;
                    prev_q     <= result_c;
                    stable_q   <= stable_d;
                end else begin
                    acc_cnt_q  <= merged_cnt_c;
                    acc_code_q <= merged_code_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

    localparam int SCAN = 64;   // 4 columns * 2^4 cycles

    logic        mclk;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_tick;
    logic        release_tick;
    logic [15:0] keys;          // bit r*4+c set while key (r,c) is down

    int errors;
    int checks;
    int cyc;
    int kt_cnt;
    int rt_cnt;
    int both_cnt;
    int last_kt_cyc;
    int kt0;
    int rt0;
    int press_cyc;

    keypad_scanner #(
        .SCAN_BITS (4),
        .DB_SCANS  (4)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_tick     (key_tick),
        .release_tick (release_tick)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Keypad: a pressed key shorts its row to its column while that column is low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (key_tick) begin
            kt_cnt      <= kt_cnt + 1;
            last_kt_cyc <= cyc;
        end
        if (release_tick) rt_cnt <= rt_cnt + 1;
        if (key_tick && release_tick) both_cnt <= both_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        cyc = 0; kt_cnt = 0; rt_cnt = 0; both_cnt = 0; last_kt_cyc = 0;
        keys = '0;
        reset = 1'b0;

        step(5);
        chk("rst_col",      32'(col),          32'(4'b1110));
        chk("rst_code",     32'(key_code),     32'(0));
        chk("rst_valid",    32'(key_valid),    32'(0));
        chk("rst_ktick",    32'(key_tick),     32'(0));
        chk("rst_rtick",    32'(release_tick), 32'(0));

        // Reset asserted mid-scan acts without a clock edge.
        reset = 1'b1;
        step(40);
        #2 reset = 1'b0;
        #1 chk("async_rst_col", 32'(col), 32'(4'b1110));
        step(3);
        reset = 1'b1;

        step(15);
        chk("rot_hold",  32'(col), 32'(4'b1110));
        step(1);
        chk("rot_c1",    32'(col), 32'(4'b1101));
        step(16);
        chk("rot_c2",    32'(col), 32'(4'b1011));

        // Press '5' (r1,c1) and hold 10 scans.
        kt0 = kt_cnt; press_cyc = cyc;
        keys[1*4+1] = 1'b1;
        step(10 * SCAN);
        chk("press5_ticks", 32'(kt_cnt - kt0), 32'(1));
        chk("press5_code",  32'(key_code),     32'(4'h5));
        chk("press5_valid", 32'(key_valid),    32'(1));
        chk("press5_lat",   32'((last_kt_cyc - press_cyc) >= 4*SCAN && (last_kt_cyc - press_cyc) <= 5*SCAN), 32'(1));

        // Release '5'.
        rt0 = rt_cnt;
        keys = '0;
        step(4 * SCAN);
        chk("rel5_early",   32'(rt_cnt - rt0), 32'(0));
        step(6 * SCAN);
        chk("rel5_ticks",   32'(rt_cnt - rt0), 32'(1));
        chk("rel5_valid",   32'(key_valid),    32'(0));
        chk("rel5_code",    32'(key_code),     32'(4'h5));
        chk("rel5_no_kt",   32'(kt_cnt - kt0), 32'(1));

        // Bounce on 'D' (r3,c3): toggle every scan for 8 scans, then hold.
        kt0 = kt_cnt;
        for (int i = 0; i < 4; i++) begin
            keys[15] = 1'b1;
            step(SCAN);
            keys[15] = 1'b0;
            step(SCAN);
        end
        chk("bounce_none",  32'(kt_cnt - kt0), 32'(0));
        keys[15] = 1'b1;
        step(4 * SCAN);
        chk("bounce_tick",  32'(kt_cnt - kt0), 32'(1));
        chk("bounce_code",  32'(key_code),     32'(4'hD));
        chk("bounce_valid", 32'(key_valid),    32'(1));
        keys = '0;
        step(6 * SCAN);
        chk("bounce_rel",   32'(key_valid),    32'(0));

        // Two keys together are ignored; dropping one accepts the other.
        kt0 = kt_cnt;
        keys[0]  = 1'b1;
        keys[10] = 1'b1;
        step(8 * SCAN);
        chk("multi_none",   32'(kt_cnt - kt0), 32'(0));
        chk("multi_valid",  32'(key_valid),    32'(0));
        keys[10] = 1'b0;
        step(6 * SCAN);
        chk("multi_tick",   32'(kt_cnt - kt0), 32'(1));
        chk("multi_code",   32'(key_code),     32'(4'h1));

        // Reset while pressed, key still held.
        step(5);
        #2 reset = 1'b0;
        #1;
        chk("prst_valid",   32'(key_valid), 32'(0));
        chk("prst_code",    32'(key_code),  32'(0));
        chk("prst_col",     32'(col),       32'(4'b1110));
        step(4);
        reset = 1'b1;
        kt0 = kt_cnt;
        step(4 * SCAN - 1);
        chk("reacc_early",  32'(key_tick), 32'(0));
        step(1);
        chk("reacc_tick",   32'(key_tick), 32'(1));
        chk("reacc_code",   32'(key_code), 32'(4'h1));
        step(1);
        chk("reacc_pulse",  32'(key_tick), 32'(0));
        chk("reacc_count",  32'(kt_cnt - kt0), 32'(1));

        chk("never_both",   32'(both_cnt), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
